// File: rtl/lms_monitor_pkg.sv
// Shared types, constants and the saturating-square helper for the LMS
// convergence monitor.
package lms_monitor_pkg;

    // Width of the warm-up and hold counters.
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // State codes seen on the state output. WARMUP and TRACKING share TRACK.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        CONV  = 2'd2,
        DIVG  = 2'd3
    } state_e;

    // Square a signed sample, drop frac fractional bits and clamp to an
    // unsigned value of the given width. Valid for width up to 32.
    function automatic logic [63:0] sat_square(
        input logic signed [31:0] err,
        input int unsigned        frac,
        input int unsigned        width
    );
        logic signed [63:0] e64;
        logic [63:0] prod;
        logic [63:0] shifted;
        logic [63:0] max_val;
        e64     = 64'(err);
        prod    = e64 * e64;
        shifted = prod >> frac;
        max_val = (64'd1 << width) - 64'd1;
        return (shifted > max_val) ? max_val : shifted;
    endfunction

endpackage

// File: rtl/error_square_sat.sv
// Stage 1 of the monitor: squares the error sample, rescales it to FRAC
// fractional bits, saturates it to WIDTH bits and registers it with its valid.
module error_square_sat
    import lms_monitor_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 14
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] error,
    output logic [WIDTH-1:0]        sq,
    output logic                    v1
);

    logic [WIDTH-1:0] sq_d, sq_q;
    logic             v1_d, v1_q;

    // Compute the saturated square; hold the last value when no sample arrives.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
        sq_d = sq_q;
        v1_d = in_valid;
        if (in_valid) begin
            sq_d = WIDTH'(sat_square(32'(error), FRAC, WIDTH));
        end
    end

    // Stage-1 pipeline register; reset drops any sample in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rstn) begin
            sq_q <= '0;
            v1_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
            v1_q <= v1_d;
        end
    end

    assign sq = sq_q;
    assign v1 = v1_q;

endmodule

// File: rtl/lms_convergence_monitor.sv
// Leaky-average MSE estimator plus adaptation classifier for the LMS filter:
// warms up, tracks, declares convergence (with freeze request) or divergence.
module lms_convergence_monitor
    import lms_monitor_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int FRAC        = 14,
    parameter int ALPHA_SHIFT = 4,
    parameter int WARMUP      = 32,
    parameter int HOLD        = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    enable,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] error,
    input  logic [WIDTH-1:0]        conv_thresh,
    input  logic [WIDTH-1:0]        div_thresh,
    input  logic                    freeze_en,
    input  logic                    clear_div,
    output logic [WIDTH-1:0]        mse,
    output logic                    mse_valid,
    output logic [1:0]              state,
    output logic                    converged,
    output logic                    diverged,
    output logic                    freeze
);

    localparam logic [CNT_W-1:0] WARM_END = CNT_W'(WARMUP);
    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD);

    logic [WIDTH-1:0] sq;
    logic             v1;

    error_square_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_square (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .error    (error),
        .sq       (sq),
        .v1       (v1)
    );

    state_e           state_d, state_q;
    logic             warm_d, warm_q;
    logic [CNT_W-1:0] warm_cnt_d, warm_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d, hold_cnt_q;
    logic [WIDTH-1:0] mse_d, mse_q;
    logic             mse_valid_d, mse_valid_q;
    logic             converged_d, converged_q;
    logic             diverged_d, diverged_q;
    logic             freeze_d, freeze_q;

    // The difference needs WIDTH+1 signed bits; one more bit of headroom
    // keeps the sum exact so the range assertion can see any excursion.
    logic signed [WIDTH+1:0] diff;
    logic signed [WIDTH+1:0] step;
    logic signed [WIDTH+1:0] mse_sum;
    logic [WIDTH-1:0]        mse_next;
    logic                    above_div;
    logic                    below_conv;

    // Leaky average: mse + floor((sq - mse) / 2^ALPHA_SHIFT), then thresholds on the new value.
    always_comb begin
        diff       = $signed({2'b00, sq}) - $signed({2'b00, mse_q});
        step       = diff >>> ALPHA_SHIFT;
        mse_sum    = $signed({2'b00, mse_q}) + step;
        mse_next   = mse_sum[WIDTH-1:0];
        above_div  = (mse_next > div_thresh);
        below_conv = (mse_next < conv_thresh);
    end

    // The average moves a fraction of the way toward sq, so it never leaves [0, 2^WIDTH-1].
    a_mse_range: assert property (@(posedge clk) disable iff (!rstn)
        v1 |-> (mse_sum[WIDTH+1:WIDTH] == 2'b00));

    // Next-state logic: enable low wins, then clear_div, then threshold evaluation.
    always_comb begin
        state_d     = state_q;
        warm_d      = warm_q;
        warm_cnt_d  = warm_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        mse_d       = mse_q;
        mse_valid_d = 1'b0;

        if (!enable) begin
            state_d    = IDLE;
            warm_d     = 1'b1;
            warm_cnt_d = '0;
            hold_cnt_d = '0;
            mse_d      = '0;
        end else if (state_q == IDLE) begin
            state_d    = TRACK;
            warm_d     = 1'b1;
            warm_cnt_d = '0;
            hold_cnt_d = '0;
        end else begin
            if (v1) begin
                mse_d       = mse_next;
                mse_valid_d = 1'b1;
            end
            if ((state_q == DIVG) && clear_div) begin
                // Divergence on this same update is re-detected on the next one.
                state_d    = TRACK;
                hold_cnt_d = '0;
            end else if (v1) begin
                case (state_q)
                    TRACK: begin
                        if (warm_q) begin
                            warm_cnt_d = warm_cnt_q + CNT_ONE;
                            if (warm_cnt_d == WARM_END) begin
                                warm_d     = 1'b0;
                                hold_cnt_d = '0;
                            end
                        end else if (above_div) begin
                            state_d = DIVG;
                        end else if (below_conv) begin
                            hold_cnt_d = hold_cnt_q + CNT_ONE;
                            if (hold_cnt_d == HOLD_END) begin
                                state_d = CONV;
                            end
                        end else begin
                            hold_cnt_d = '0;
                        end
                    end
                    CONV: begin
                        if (above_div) begin
                            state_d = DIVG;
                        end else if (!below_conv) begin
                            state_d    = TRACK;
                            hold_cnt_d = '0;
                        end
                    end
                    default: begin
                        // DIVG is sticky until clear_div; IDLE is handled above.
                    end
                endcase
            end
        end

        converged_d = (state_d == CONV);
        diverged_d  = (state_d == DIVG);
        freeze_d    = converged_q & freeze_en;
    end

    // State, average and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            warm_q      <= 1'b1;
            warm_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            mse_q       <= '0;
            mse_valid_q <= 1'b0;
            converged_q <= 1'b0;
            diverged_q  <= 1'b0;
            freeze_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_q      <= warm_d;
            warm_cnt_q  <= warm_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            mse_q       <= mse_d;
            mse_valid_q <= mse_valid_d;
            converged_q <= converged_d;
            diverged_q  <= diverged_d;
            freeze_q    <= freeze_d;
        end
    end

    assign mse       = mse_q;
    assign mse_valid = mse_valid_q;
    assign state     = state_q;
    assign converged = converged_q;
    assign diverged  = diverged_q;
    assign freeze    = freeze_q;

endmodule

// File: tb/tb_lms_convergence_monitor.sv
// Directed bench for lms_convergence_monitor with hand-computed MSE sequences.
module tb_lms_convergence_monitor;

    localparam int WIDTH = 16;

    // Tracking phase, conv_thresh=250, starting from mse=246 (hold resets at 250).
    localparam int TRK_ERR [12] = '{0, 0, 0, 4048, 0, 0, 0, 0, 0, 0, 0, 0};
    localparam int TRK_MSE [12] = '{230, 215, 201, 250, 234, 219, 205, 192, 180, 168, 157, 147};
    localparam int TRK_ST  [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2};
    // Re-convergence, conv_thresh=2000, error=0, starting from mse=1161.
    localparam int RCV_MSE [8]  = '{1088, 1020, 956, 896, 840, 787, 737, 690};
    // Warm-up with error=16384 (sq=16384), div_thresh=1000.
    localparam int DIV_MSE [4]  = '{1024, 1984, 2884, 3727};

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    enable;
    logic                    in_valid;
    logic signed [WIDTH-1:0] error;
    logic [WIDTH-1:0]        conv_thresh;
    logic [WIDTH-1:0]        div_thresh;
    logic                    freeze_en;
    logic                    clear_div;
    logic [WIDTH-1:0]        mse;
    logic                    mse_valid;
    logic [1:0]              state;
    logic                    converged;
    logic                    diverged;
    logic                    freeze;

    int n_checks = 0;
    int n_fail   = 0;

    lms_convergence_monitor #(
        .WIDTH       (WIDTH),
        .FRAC        (14),
        .ALPHA_SHIFT (4),
        .WARMUP      (4),
        .HOLD        (8)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (enable),
        .in_valid    (in_valid),
        .error       (error),
        .conv_thresh (conv_thresh),
        .div_thresh  (div_thresh),
        .freeze_en   (freeze_en),
        .clear_div   (clear_div),
        .mse         (mse),
        .mse_valid   (mse_valid),
        .state       (state),
        .converged   (converged),
        .diverged    (diverged),
        .freeze      (freeze)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One isolated sample; returns on the negedge after its mse update.
    task automatic send(input logic signed [WIDTH-1:0] e);
        in_valid = 1'b1;
        error    = e;
        @(negedge clk);
        in_valid = 1'b0;
        error    = '0;
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input int exp_mse, input int exp_state);
        check({tag, ".mse"}, int'(mse), exp_mse);
        check({tag, ".state"}, int'(state), exp_state);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rstn        = 1'b0;
        enable      = 1'b0;
        in_valid    = 1'b0;
        error       = '0;
        conv_thresh = '0;
        div_thresh  = 16'hFFFF;
        freeze_en   = 1'b1;
        clear_div   = 1'b0;

        // Reset state
        repeat (3) tick();
        expect_out("rst", 0, 0);
        check("rst.mse_valid", int'(mse_valid), 0);
        check("rst.converged", int'(converged), 0);
        check("rst.diverged", int'(diverged), 0);
        check("rst.freeze", int'(freeze), 0);
        rstn = 1'b1;
        tick();
        check("idle.state", int'(state), 0);

        // Back-to-back error=0.5 -> sq=4096, two-edge latency
        enable = 1'b1;
        tick();
        check("en.state", int'(state), 1);
        in_valid = 1'b1;
        error    = 16'sd8192;
        tick();
        check("lat1.mse_valid", int'(mse_valid), 0);
        check("lat1.mse", int'(mse), 0);
        tick();
        check("b2b1.mse_valid", int'(mse_valid), 1);
        expect_out("b2b1", 256, 1);
        tick();
        check("b2b2.mse_valid", int'(mse_valid), 1);
        expect_out("b2b2", 496, 1);
        tick();
        expect_out("b2b3", 721, 1);
        in_valid = 1'b0;
        error    = '0;
        tick();
        expect_out("b2b4", 931, 1);
        check("b2b4.mse_valid", int'(mse_valid), 1);
        tick();
        check("hold.mse_valid", int'(mse_valid), 0);
        expect_out("hold", 931, 1);

        // enable low clears to IDLE; saturating square from mse=0
        enable = 1'b0;
        tick();
        expect_out("dis", 0, 0);
        enable = 1'b1;
        tick();
        check("sat.en_state", int'(state), 1);
        send(-16'sd32768);
        expect_out("sat", 4095, 1);
        check("sat.mse_valid", int'(mse_valid), 1);

        // Convergence: warm up to mse=246, then track with conv_thresh=250
        enable = 1'b0;
        tick();
        enable      = 1'b1;
        conv_thresh = 16'd250;
        div_thresh  = 16'hFFFF;
        tick();
        send(16'sd8869);
        expect_out("warm1", 300, 1);
        send(16'sd0);
        expect_out("warm2", 281, 1);
        send(16'sd0);
        expect_out("warm3", 263, 1);
        send(16'sd0);
        expect_out("warm4", 246, 1);
        check("warm4.converged", int'(converged), 0);
        for (int i = 0; i < 12; i++) begin
            send(16'(TRK_ERR[i]));
            expect_out($sformatf("trk%0d", i), TRK_MSE[i], TRK_ST[i]);
        end
        check("conv.converged", int'(converged), 1);
        check("conv.freeze_early", int'(freeze), 0);
        tick();
        check("conv.freeze", int'(freeze), 1);
        freeze_en = 1'b0;
        tick();
        check("frz_off.freeze", int'(freeze), 0);
        freeze_en = 1'b1;
        tick();
        check("frz_on.freeze", int'(freeze), 1);

        // Leave CONVERGED on mse >= conv_thresh; freeze drops one edge later
        send(16'sd16384);
        expect_out("unconv", 1161, 1);
        check("unconv.converged", int'(converged), 0);
        check("unconv.freeze_lag", int'(freeze), 1);
        tick();
        check("unconv.freeze", int'(freeze), 0);

        // Re-converge with a higher threshold
        conv_thresh = 16'd2000;
        for (int i = 0; i < 8; i++) begin
            send(16'sd0);
            expect_out($sformatf("rcv%0d", i), RCV_MSE[i], (i == 7) ? 2 : 1);
        end
        tick();
        check("rcv.freeze", int'(freeze), 1);

        // enable dropped while converged
        enable = 1'b0;
        tick();
        expect_out("drop", 0, 0);
        check("drop.converged", int'(converged), 0);
        check("drop.freeze_lag", int'(freeze), 1);
        tick();
        check("drop.freeze", int'(freeze), 0);

        // Divergence: warm-up ignores mse>1000, first tracking update trips it
        enable      = 1'b1;
        conv_thresh = 16'd0;
        div_thresh  = 16'd1000;
        tick();
        check("div.en_state", int'(state), 1);
        for (int i = 0; i < 4; i++) begin
            send(16'sd16384);
            expect_out($sformatf("dwarm%0d", i), DIV_MSE[i], 1);
            check($sformatf("dwarm%0d.diverged", i), int'(diverged), 0);
        end
        send(16'sd16384);
        expect_out("div", 4518, 3);
        check("div.diverged", int'(diverged), 1);
        send(16'sd0);
        expect_out("sticky", 4235, 3);
        check("sticky.diverged", int'(diverged), 1);
        clear_div = 1'b1;
        tick();
        clear_div = 1'b0;
        expect_out("clr", 4235, 1);
        check("clr.diverged", int'(diverged), 0);
        send(16'sd0);
        expect_out("redet", 3970, 3);

        // clear_div on the same edge as an update above div_thresh
        in_valid = 1'b1;
        error    = '0;
        tick();
        in_valid  = 1'b0;
        clear_div = 1'b1;
        tick();
        clear_div = 1'b0;
        expect_out("clr_upd", 3721, 1);
        check("clr_upd.diverged", int'(diverged), 0);
        check("clr_upd.mse_valid", int'(mse_valid), 1);
        send(16'sd0);
        expect_out("redet2", 3488, 3);

        // Reset with a sample in flight
        in_valid = 1'b1;
        error    = 16'sd16384;
        tick();
        rstn     = 1'b0;
        in_valid = 1'b0;
        error    = '0;
        tick();
        expect_out("mid_rst", 0, 0);
        check("mid_rst.diverged", int'(diverged), 0);
        check("mid_rst.mse_valid", int'(mse_valid), 0);
        check("mid_rst.freeze", int'(freeze), 0);
        rstn = 1'b1;
        tick();
        expect_out("post_rst", 0, 1);
        tick();
        check("post_rst.mse_valid", int'(mse_valid), 0);
        check("post_rst.mse", int'(mse), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
